bitstream_queue: RTL and testbench

- Parametrised MSB-first bit queue between the SDRAM read port and the video decoder datapath.
- Prefetches WORD_W-bit words over the ram_rden/ram_ack handshake and presents a PEEK_W-bit window.
- Accepts a variable-length take of 0..PEEK_W bits per cycle.
- Generalises the fixed 48-bit, 16-bit-word queue: width, depth and take size are parameters; adds a flush/reload and a consumer underflow flag.

---
 rtl/bitstream_queue.sv | 116 +++++++++++
 tb/tb_bitstream_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_queue.sv
// MSB-first bit queue: prefetches RAM words, exposes a PEEK_W window, consumes 0..PEEK_W bits per cycle.
// Latency: appended words and takes are visible on peek/fill one cycle later; one outstanding read at a time.
// Backpressure: fetching pauses while the queue lacks room for a whole word; over-long takes are dropped and flagged.
// Optional build macro BITQ_STATS_EN adds words_fetched / stall_cycles counters.
module bitstream_queue #(
    parameter int WORD_W  = 16,
    parameter int QUEUE_W = 48,
    parameter int ADDR_W  = 25,
    parameter int PEEK_W  = 16
) (
    input  logic                           clk50,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           load,
    input  logic [ADDR_W-1:0]              start_addr,
    output logic                           ram_rden,
    output logic [ADDR_W-1:0]              ram_addr,
    input  logic [WORD_W-1:0]              ram_data,
    input  logic                           ram_ack,
    output logic [PEEK_W-1:0]              peek,
    output logic [$clog2(QUEUE_W+1)-1:0]   fill,
    input  logic                           take_en,
    input  logic [$clog2(PEEK_W+1)-1:0]    take_n,
`ifdef BITQ_STATS_EN
    output logic [31:0]                    words_fetched,
    output logic [31:0]                    stall_cycles,
`endif
    output logic                           underflow
);

    localparam int FW = $clog2(QUEUE_W+1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]         state, state_next;
    logic [QUEUE_W-1:0] q, q_taken, q_next, word_ext;
    logic [FW-1:0]      fill_taken, fill_next;
    logic               discard, discard_next;
    logic               take_req, take_bad, take_ok, ack_ok, fetch_ok;

    // Oldest bit sits at the MSB; bits below fill are kept zero so the window pads itself.
    assign peek     = q[QUEUE_W-1 -: PEEK_W];
    assign ram_rden = (state == ST_REQ);

    // Next-state: take applies to pre-ack contents, then the acked word lands just below the survivors.
    always_comb begin
        take_req   = take_en && !load;
        take_bad   = take_req && (FW'(take_n) > fill);
        take_ok    = take_req && !take_bad && (take_n != '0);
        ack_ok     = ram_ack && (state == ST_REQ) && !load;
        q_taken    = take_ok ? (q << take_n) : q;
        fill_taken = take_ok ? (fill - FW'(take_n)) : fill;
        word_ext   = {ram_data, {(QUEUE_W-WORD_W){1'b0}}};
        q_next     = q_taken;
        fill_next  = fill_taken;
        if (load) begin
            q_next    = '0;
            fill_next = '0;
        end else if (ack_ok) begin
            q_next    = q_taken | (word_ext >> fill_taken);
            fill_next = fill_taken + FW'(WORD_W);
        end
        // A flush with a read in flight must swallow that read's ack when it eventually arrives.
        if (load)
            discard_next = (discard || (state == ST_REQ)) && !ram_ack;
        else
            discard_next = discard && !ram_ack;
        fetch_ok = run && !discard_next && (fill_next <= FW'(QUEUE_W-WORD_W));
        state_next = state;
        if (load)
            state_next = ST_IDLE;
        else if (state == ST_IDLE && fetch_ok)
            state_next = ST_REQ;
        else if (state == ST_REQ && ram_ack)
            state_next = fetch_ok ? ST_REQ : ST_IDLE;
    end

    // Queue, fill, fetch FSM, address and sticky underflow registers.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state     <= ST_IDLE;
            q         <= '0;
            fill      <= '0;
            discard   <= 1'b0;
            ram_addr  <= '0;
            underflow <= 1'b0;
        end else begin
            state     <= state_next;
            q         <= q_next;
            fill      <= fill_next;
            discard   <= discard_next;
            if (load)
                ram_addr <= start_addr;
            else if (ack_ok)
                ram_addr <= ram_addr + ADDR_W'(1);
            underflow <= load ? 1'b0 : (underflow | take_bad);
        end
    end

`ifdef BITQ_STATS_EN
    // Saturating activity counters, cleared together with the queue on load.
    always_ff @(posedge clk50) begin
        if (reset || load) begin
            words_fetched <= '0;
            stall_cycles  <= '0;
        end else begin
            if (ack_ok && words_fetched != '1)
                words_fetched <= words_fetched + 32'd1;
            if (take_bad && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitstream_queue.sv
// Bench for bitstream_queue: bit-level scoreboard fed by acked words, drained by takes.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that same point.
// Fetch waits are bounded; an expired wait counts as a failed check.
module tb_bitstream_queue;

    logic        clk50 = 1'b0;
    logic        reset, run, load;
    logic [24:0] start_addr;
    logic        ram_rden;
    logic [24:0] ram_addr;
    logic [15:0] ram_data;
    logic        ram_ack;
    logic [15:0] peek;
    logic [5:0]  fill;
    logic        take_en;
    logic [4:0]  take_n;
    logic        underflow;
`ifdef BITQ_STATS_EN
    logic [31:0] words_fetched, stall_cycles;
`endif

    bitstream_queue dut (
        .clk50(clk50), .reset(reset), .run(run), .load(load), .start_addr(start_addr),
        .ram_rden(ram_rden), .ram_addr(ram_addr), .ram_data(ram_data), .ram_ack(ram_ack),
        .peek(peek), .fill(fill), .take_en(take_en), .take_n(take_n),
`ifdef BITQ_STATS_EN
        .words_fetched(words_fetched), .stall_cycles(stall_cycles),
`endif
        .underflow(underflow)
    );

    always #5 clk50 = ~clk50;

    int n_chk  = 0;
    int n_pass = 0;

    // Scoreboard: stream bits in arrival order, plus sticky underflow expectation.
    bit   sb_bits[$];
    logic sb_uf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    function automatic logic [15:0] sb_peek();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i < sb_bits.size()) r[15-i] = sb_bits[i];
        return r;
    endfunction

    task automatic sb_take(input int n);
        if (n > sb_bits.size()) sb_uf = 1'b1;
        else for (int i = 0; i < n; i++) void'(sb_bits.pop_front());
    endtask

    task automatic sb_push(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) sb_bits.push_back(w[i]);
    endtask

    task automatic check_sb(input string tag);
        chk({tag, ".peek"}, 64'(peek), 64'(sb_peek()));
        chk({tag, ".fill"}, 64'(fill), 64'(sb_bits.size()));
        chk({tag, ".uf"},   64'(underflow), 64'(sb_uf));
    endtask

    task automatic wait_req(input logic [24:0] exp_addr, input string tag);
        for (int i = 0; i < 20 && !ram_rden; i++) step();
        chk({tag, ".rden"}, 64'(ram_rden), 64'd1);
        if (ram_rden) chk({tag, ".addr"}, 64'(ram_addr), 64'(exp_addr));
    endtask

    task automatic do_ack(input logic [15:0] w, input logic t, input int n, input string tag);
        ram_ack = 1'b1; ram_data = w; take_en = t; take_n = 5'(n);
        if (t) sb_take(n);
        sb_push(w);
        step();
        ram_ack = 1'b0; ram_data = '0; take_en = 1'b0; take_n = '0;
        check_sb(tag);
    endtask

    task automatic do_take(input int n, input string tag);
        take_en = 1'b1; take_n = 5'(n);
        sb_take(n);
        step();
        take_en = 1'b0; take_n = '0;
        check_sb(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; load = 1'b0; start_addr = '0;
        ram_data = '0; ram_ack = 1'b0; take_en = 1'b0; take_n = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst.rden", 64'(ram_rden), 64'd0);
        chk("rst.addr", 64'(ram_addr), 64'd0);
        check_sb("rst");

        // 1: fill the queue with three words
        load = 1'b1; start_addr = 25'h0000100; run = 1'b1;
        step();
        load = 1'b0;
        wait_req(25'h100, "t1a");
        do_ack(16'h3449, 1'b0, 0, "t1a");
        wait_req(25'h101, "t1b");
        do_ack(16'h7220, 1'b0, 0, "t1b");
        wait_req(25'h102, "t1c");
        do_ack(16'h13C1, 1'b0, 0, "t1c");
        chk("t1.rden_off", 64'(ram_rden), 64'd0);
        chk("t1.fill48",   64'(fill), 64'd48);
        chk("t1.peek",     64'(peek), 64'h3449);
`ifdef BITQ_STATS_EN
        chk("t1.words", 64'(words_fetched), 64'd3);
`endif

        // 2: takes, and refetch once there is room
        do_take(4, "t2a");
        chk("t2a.peek_c", 64'(peek), 64'h4497);
        do_take(16, "t2b");
        chk("t2b.peek_c", 64'(peek), 64'h2201);
        chk("t2b.fill_c", 64'(fill), 64'd28);
        chk("t2b.rden",   64'(ram_rden), 64'd1);
        chk("t2b.addr",   64'(ram_addr), 64'h103);

        // 3: take and ack in the same cycle
        wait_req(25'h103, "t3");
        do_ack(16'hB0F0, 1'b1, 8, "t3");
        chk("t3.fill_c", 64'(fill), 64'd36);
        chk("t3.peek_c", 64'(peek), 64'h013C);
        chk("t3.rden",   64'(ram_rden), 64'd0);

        // 4: underflow on an over-long take, zero take, then flush
        run = 1'b0;
        do_take(16, "t4a");
        do_take(16, "t4b");
        chk("t4.fill4", 64'(fill), 64'd4);
        do_take(5, "t4c");
        chk("t4.uf", 64'(underflow), 64'd1);
        do_take(0, "t4d");
`ifdef BITQ_STATS_EN
        chk("t4.stall", 64'(stall_cycles), 64'd1);
`endif
        load = 1'b1; start_addr = 25'h104;
        step();
        load = 1'b0;
        sb_bits.delete(); sb_uf = 1'b0;
        check_sb("t4.load");
        chk("t4.rden", 64'(ram_rden), 64'd0);

        // 5: flush with a read in flight, discard its ack, then address wrap
        run = 1'b1;
        wait_req(25'h104, "t5a");
        load = 1'b1; start_addr = 25'h1FFFFFF; take_en = 1'b1; take_n = 5'd1;
        step();
        load = 1'b0; take_en = 1'b0; take_n = '0;
        chk("t5.rden_drop", 64'(ram_rden), 64'd0);
        chk("t5.addr_ld",   64'(ram_addr), 64'h1FFFFFF);
        check_sb("t5.load");
        ram_ack = 1'b1; ram_data = 16'hAAAA;
        step();
        ram_ack = 1'b0; ram_data = '0;
        check_sb("t5.discard");
        wait_req(25'h1FFFFFF, "t5b");
        run = 1'b0;
        do_ack(16'h1234, 1'b0, 0, "t5b");
        chk("t5.halt", 64'(ram_rden), 64'd0);
        run = 1'b1;
        wait_req(25'h0, "t5c");
        do_ack(16'h5678, 1'b0, 0, "t5c");
`ifdef BITQ_STATS_EN
        chk("t5.words", 64'(words_fetched), 64'd2);
`endif

        // 6: reset during a request; the late ack must be ignored
        wait_req(25'h1, "t6");
        reset = 1'b1; run = 1'b0;
        step();
        reset = 1'b0;
        sb_bits.delete(); sb_uf = 1'b0;
        chk("t6.rden", 64'(ram_rden), 64'd0);
        check_sb("t6.rst");
        ram_ack = 1'b1; ram_data = 16'hFFFF;
        step();
        ram_ack = 1'b0; ram_data = '0;
        check_sb("t6.ack");
        step(); step(); step();
        chk("t6.idle", 64'(ram_rden), 64'd0);
        chk("t6.addr", 64'(ram_addr), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
